// File: rtl/neural_soc_result_mailbox_if.sv
// Result mailbox bus bundle.
// Groups the core-side byte stream and the software PIO signals:
//   result_valid / result_data / result_last : byte stream from the neural core
//   result_ready                              : mailbox can take a byte this cycle
//   sw_ack                                    : software PIO bit, each toggle frees one word
//   to_sw_word                                : registered word for the software input PIO
// master = core/software side, slave = mailbox.
interface neural_soc_result_mailbox_if;
  logic        result_valid;
  logic [7:0]  result_data;
  logic        result_last;
  logic        result_ready;
  logic        sw_ack;
  logic [31:0] to_sw_word;

  modport master (
    output result_valid,
    output result_data,
    output result_last,
    output sw_ack,
    input  result_ready,
    input  to_sw_word
  );

  modport slave (
    input  result_valid,
    input  result_data,
    input  result_last,
    input  sw_ack,
    output result_ready,
    output to_sw_word
  );
endinterface

// File: rtl/neural_soc_result_mailbox.sv
// Neural SoC result mailbox.
// Packs 8-bit neuron results three per word, buffers up to two packed words
// and presents the oldest one with a header to a software-readable PIO.
// Ports:
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   mbox    : slave side of the mailbox bus (byte stream in, ready out,
//             sw_ack in, to_sw_word out)
// Word layout: [31] valid, [30] last, [29:28] byte count, [27:24] sequence,
// [23:0] bytes with the first byte in [7:0]; all zero when nothing is buffered.
module neural_soc_result_mailbox (
  input  logic                               clk,
  input  logic                               reset_n,
  neural_soc_result_mailbox_if.slave         mbox
);

  // Header plus payload of a closing word.
  function automatic logic [31:0] make_word(input logic        last,
                                            input logic [1:0]  fill,
                                            input logic [3:0]  seq,
                                            input logic [23:0] bytes);
    make_word = {1'b1, last, fill + 2'd1, seq, bytes};
  endfunction

  logic [1:0]  fill_p0;
  logic [23:0] pack_p0;
  logic [31:0] fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [3:0]  seq;
  logic        ack_prev;
  logic [31:0] word_p1;

  logic        xfer;
  logic        close;
  logic        push;
  logic        pop;
  logic [23:0] pack_next;
  logic [31:0] push_word;

  // Ready depends only on buffer occupancy, so any accepted byte can close a
  // word without overflowing.
  assign mbox.result_ready = (count < 2'd2);
  assign mbox.to_sw_word   = word_p1;

  assign xfer  = mbox.result_valid && mbox.result_ready;
  assign close = xfer && ((fill_p0 == 2'd2) || mbox.result_last);
  assign push  = close;
  // A toggle with nothing buffered is dropped; ack_prev still follows sw_ack.
  assign pop   = (mbox.sw_ack != ack_prev) && (count != 2'd0);

  always_comb begin
    pack_next = pack_p0;
    case (fill_p0)
      2'd0:    pack_next[7:0]   = mbox.result_data;
      2'd1:    pack_next[15:8]  = mbox.result_data;
      default: pack_next[23:16] = mbox.result_data;
    endcase
  end

  assign push_word = make_word(mbox.result_last, fill_p0, seq, pack_next);

  // Stage p0: packer, FIFO and acknowledge tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_p0     <= 2'd0;
      pack_p0     <= 24'd0;
      fifo_mem[0] <= 32'd0;
      fifo_mem[1] <= 32'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      seq         <= 4'd0;
      ack_prev    <= 1'b0;
    end else begin
      ack_prev <= mbox.sw_ack;

      if (xfer) begin
        if (close) begin
          fill_p0 <= 2'd0;
          pack_p0 <= 24'd0;
        end else begin
          fill_p0 <= fill_p0 + 2'd1;
          pack_p0 <= pack_next;
        end
      end

      if (push) begin
        fifo_mem[wr_ptr] <= push_word;
        wr_ptr           <= ~wr_ptr;
        seq              <= seq + 4'd1;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: registered copy of the current head for the software PIO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_p1 <= 32'd0;
    end else begin
      word_p1 <= (count != 2'd0) ? fifo_mem[rd_ptr] : 32'd0;
    end
  end

endmodule

// File: tb/tb_neural_soc_result_mailbox.sv
module tb_neural_soc_result_mailbox;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  neural_soc_result_mailbox_if mbox_if ();

  neural_soc_result_mailbox dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mbox    (mbox_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference packer state.
  int          m_fill = 0;
  logic [23:0] m_data = 24'd0;
  logic [3:0]  m_seq = 4'd0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] expected_head();
    if (exp_q.size() > 0) return exp_q[0];
    return 32'd0;
  endfunction

  task automatic model_clear();
    m_fill = 0;
    m_data = 24'd0;
    m_seq  = 4'd0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    m_data[8*m_fill +: 8] = d;
    if (m_fill == 2 || l) begin
      exp_q.push_back({1'b1, l, 2'(m_fill + 1), m_seq, m_data});
      m_seq  = m_seq + 4'd1;
      m_fill = 0;
      m_data = 24'd0;
    end else begin
      m_fill = m_fill + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    mbox_if.result_valid = 1'b1;
    mbox_if.result_data  = d;
    mbox_if.result_last  = l;
    while (!mbox_if.result_ready && n < 50) begin
      tick();
      n++;
    end
    if (!mbox_if.result_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout ready=%0b required=1", mbox_if.result_ready);
    end else begin
      @(posedge clk);
      model_accept(d, l);
      #1;
    end
    mbox_if.result_valid = 1'b0;
    mbox_if.result_last  = 1'b0;
  endtask

  task automatic toggle_ack();
    mbox_if.sw_ack = ~mbox_if.sw_ack;
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    #1;
  endtask

  task automatic do_reset();
    reset_n              = 1'b0;
    mbox_if.sw_ack       = 1'b0;
    mbox_if.result_valid = 1'b0;
    mbox_if.result_last  = 1'b0;
    mbox_if.result_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL reset_word got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
    total++;
    if (mbox_if.result_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", mbox_if.result_ready);
    end
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL reset_idle_word got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
  endtask

  task automatic test_three_byte();
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL three_byte_latency got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'hB0332211) begin
      bad++; $display("FAIL three_byte_word got=%h want=%h", mbox_if.to_sw_word, 32'hB0332211);
    end
    total++;
    if (mbox_if.to_sw_word !== expected_head()) begin
      bad++; $display("FAIL three_byte_model got=%h want=%h", mbox_if.to_sw_word, expected_head());
    end
  endtask

  task automatic test_short_last();
    do_reset();
    send_byte(8'hAA, 1'b1);
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'hD00000AA) begin
      bad++; $display("FAIL short_word got=%h want=%h", mbox_if.to_sw_word, 32'hD00000AA);
    end
    toggle_ack();
    total++;
    if (mbox_if.to_sw_word !== 32'hD00000AA) begin
      bad++; $display("FAIL short_pop_latency got=%h want=%h", mbox_if.to_sw_word, 32'hD00000AA);
    end
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL short_after_ack got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    total++;
    if (mbox_if.result_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready got=%b want=0", mbox_if.result_ready);
    end
    mbox_if.result_valid = 1'b1;
    mbox_if.result_data  = 8'h07;
    mbox_if.result_last  = 1'b0;
    tick();
    total++;
    if (mbox_if.result_ready !== 1'b0) begin
      bad++; $display("FAIL stall_ready got=%b want=0", mbox_if.result_ready);
    end
    total++;
    if (mbox_if.to_sw_word !== expected_head()) begin
      bad++; $display("FAIL full_head got=%h want=%h", mbox_if.to_sw_word, expected_head());
    end
    toggle_ack();
    total++;
    if (mbox_if.result_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_pop got=%b want=1", mbox_if.result_ready);
    end
    send_byte(8'h07, 1'b0);
    total++;
    if (mbox_if.to_sw_word !== expected_head() || mbox_if.to_sw_word[27:24] !== 4'd1) begin
      bad++; $display("FAIL head_seq1 got=%h want=%h", mbox_if.to_sw_word, expected_head());
    end
    send_byte(8'h08, 1'b0);
    send_byte(8'h09, 1'b0);
    for (int k = 0; k < 2; k++) begin
      toggle_ack();
      tick();
      total++;
      if (mbox_if.to_sw_word !== expected_head()) begin
        bad++; $display("FAIL drain_%0d got=%h want=%h", k, mbox_if.to_sw_word, expected_head());
      end
    end
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL drain_empty got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_byte(8'h5A, 1'b1);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    total++;
    if (mbox_if.to_sw_word !== 32'hD000005A) begin
      bad++; $display("FAIL simul_first got=%h want=%h", mbox_if.to_sw_word, 32'hD000005A);
    end
    mbox_if.result_valid = 1'b1;
    mbox_if.result_data  = 8'h63;
    mbox_if.result_last  = 1'b0;
    mbox_if.sw_ack       = ~mbox_if.sw_ack;
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_accept(8'h63, 1'b0);
    #1;
    mbox_if.result_valid = 1'b0;
    total++;
    if (mbox_if.result_ready !== 1'b1) begin
      bad++; $display("FAIL simul_ready got=%b want=1", mbox_if.result_ready);
    end
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'hB1636261 || expected_head() !== 32'hB1636261) begin
      bad++; $display("FAIL simul_new_head got=%h want=%h", mbox_if.to_sw_word, 32'hB1636261);
    end
    toggle_ack();
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL simul_count_one got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
  endtask

  task automatic test_wrap_spurious();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i + 8'h40), 1'b1);
      tick();
      total++;
      if (mbox_if.to_sw_word !== expected_head() || mbox_if.to_sw_word[27:24] !== 4'(i)) begin
        bad++; $display("FAIL wrap_word_%0d got=%h want=%h", i, mbox_if.to_sw_word, expected_head());
      end
      toggle_ack();
      tick();
      total++;
      if (mbox_if.to_sw_word !== 32'd0) begin
        bad++; $display("FAIL wrap_pop_%0d got=%h want=%h", i, mbox_if.to_sw_word, 32'd0);
      end
    end
    toggle_ack();
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL spurious_ack got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
    send_byte(8'hEE, 1'b1);
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'hD10000EE) begin
      bad++; $display("FAIL after_spurious got=%h want=%h", mbox_if.to_sw_word, 32'hD10000EE);
    end
    tick();
    total++;
    if (mbox_if.to_sw_word !== expected_head()) begin
      bad++; $display("FAIL after_spurious_hold got=%h want=%h", mbox_if.to_sw_word, expected_head());
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    mbox_if.sw_ack = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_clear();
    total++;
    if (mbox_if.to_sw_word !== 32'd0) begin
      bad++; $display("FAIL mid_reset_word got=%h want=%h", mbox_if.to_sw_word, 32'd0);
    end
    total++;
    if (mbox_if.result_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset_ready got=%b want=1", mbox_if.result_ready);
    end
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);
    tick();
    total++;
    if (mbox_if.to_sw_word !== 32'hB0D3D2D1 || expected_head() !== 32'hB0D3D2D1) begin
      bad++; $display("FAIL mid_reset_repack got=%h want=%h", mbox_if.to_sw_word, 32'hB0D3D2D1);
    end
  endtask

  initial begin
    mbox_if.result_valid = 1'b0;
    mbox_if.result_data  = 8'd0;
    mbox_if.result_last  = 1'b0;
    mbox_if.sw_ack       = 1'b0;
    test_reset();
    test_three_byte();
    test_short_last();
    test_backpressure();
    test_simultaneous();
    test_wrap_spurious();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog elapsed=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
